// File: rtl/sequenciador_contagem_if.sv
// sequenciador_contagem_if
//   Bundle of the signals exchanged between the phase sequencer and its
//   surroundings (run request, controlled counter and status outputs).
//   master : the sequencer itself (drives preset/carga and status)
//   slave  : the environment (drives habilita and the counter value Q)
//   Signals:
//     habilita  run request
//     Q         current value of the controlled down counter
//     preset    preset value for the counter
//     carga     one-cycle load strobe for the counter
//     fase      current phase index 0..3
//     fim_ciclo pulse when phase 3 completes
//     ocupado   high whenever the sequencer is not idle
//     erro      sticky watchdog flag
interface sequenciador_contagem_if;
    logic       habilita;
    logic [3:0] Q;
    logic [3:0] preset;
    logic       carga;
    logic [1:0] fase;
    logic       fim_ciclo;
    logic       ocupado;
    logic       erro;

    modport master (
        input  habilita,
        input  Q,
        output preset,
        output carga,
        output fase,
        output fim_ciclo,
        output ocupado,
        output erro
    );

    modport slave (
        output habilita,
        output Q,
        input  preset,
        input  carga,
        input  fase,
        input  fim_ciclo,
        input  ocupado,
        input  erro
    );
endinterface

// File: rtl/sequenciador_contagem.sv
// sequenciador_contagem
//   Four-phase sequencer for a 4-bit presettable down counter. Each phase
//   loads the counter with its preset, waits for the counter to reach zero
//   and then moves on to the next phase, repeating while habilita is high.
//
//   Ports:
//     clock  system clock, rising edge
//     reset  asynchronous, active-high reset
//     bus    sequenciador_contagem_if.master (habilita, Q in;
//            preset, carga, fase, fim_ciclo, ocupado, erro out)
//
//   Optional feature: define SEQUENCIADOR_WATCHDOG_EN to build a watchdog
//   that moves to ERRO when the counter stays nonzero for MAX_CICLOS cycles
//   in COUNT. Without it erro is constant 0 and ERRO is never entered.
//
//   State  | meaning
//   IDLE   | stopped, fase=0, waiting for habilita
//   LOAD   | carga high for one cycle, counter takes preset
//   ARM    | first zero check right after the load (catches preset 0)
//   COUNT  | counter running, waiting for Q==0
//   ERRO   | watchdog tripped, waits for habilita=0
module sequenciador_contagem #(
    parameter logic [3:0] PRESET0    = 4'd9,
    parameter logic [3:0] PRESET1    = 4'd5,
    parameter logic [3:0] PRESET2    = 4'd3,
    parameter logic [3:0] PRESET3    = 4'd0,
    parameter int         MAX_CICLOS = 32
) (
    input logic                      clock,
    input logic                      reset,
    sequenciador_contagem_if.master  bus
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        ARM   = 3'd2,
        COUNT = 3'd3,
        ERRO  = 3'd4
    } estado_t;

    if (MAX_CICLOS < 1 || MAX_CICLOS > 63) begin : g_max_ciclos_invalido
        $error("MAX_CICLOS must be in 1..63");
    end

    estado_t    estado;
    logic [1:0] fase_r;
    logic [3:0] preset_r;
    logic       carga_r;
    logic       fim_r;
    logic       ocupado_r;
    logic [1:0] fase_prox;

    assign fase_prox = fase_r + 2'd1;

    function automatic logic [3:0] preset_de(input logic [1:0] f);
        logic [3:0] p;
        case (f)
            2'd0:    p = PRESET0;
            2'd1:    p = PRESET1;
            2'd2:    p = PRESET2;
            default: p = PRESET3;
        endcase
        return p;
    endfunction

`ifdef SEQUENCIADOR_WATCHDOG_EN
    // The timer holds (cycles spent in COUNT - 1) at each edge, so the trip
    // lands exactly MAX_CICLOS edges after COUNT was entered.
    localparam logic [5:0] LIMITE = 6'(MAX_CICLOS - 1);
    logic [5:0] timer;
    logic       erro_r;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado    <= IDLE;
            fase_r    <= 2'd0;
            preset_r  <= PRESET0;
            carga_r   <= 1'b0;
            fim_r     <= 1'b0;
            ocupado_r <= 1'b0;
`ifdef SEQUENCIADOR_WATCHDOG_EN
            timer     <= 6'd0;
            erro_r    <= 1'b0;
`endif
        end else begin
            carga_r <= 1'b0;
            fim_r   <= 1'b0;
            case (estado)
                IDLE: begin
                    fase_r   <= 2'd0;
                    preset_r <= PRESET0;
                    if (bus.habilita) begin
                        estado    <= LOAD;
                        carga_r   <= 1'b1;
                        ocupado_r <= 1'b1;
                    end else begin
                        ocupado_r <= 1'b0;
                    end
                end
                LOAD: begin
                    estado    <= ARM;
                    ocupado_r <= 1'b1;
                end
                ARM, COUNT: begin
                    if (bus.Q == 4'd0) begin
                        // Phase complete; habilita is only looked at here,
                        // so a mid-phase drop lets the phase finish.
                        if (fase_r == 2'd3) begin
                            fim_r <= 1'b1;
                        end
                        if (bus.habilita) begin
                            estado    <= LOAD;
                            carga_r   <= 1'b1;
                            fase_r    <= fase_prox;
                            preset_r  <= preset_de(fase_prox);
                            ocupado_r <= 1'b1;
                        end else begin
                            estado    <= IDLE;
                            fase_r    <= 2'd0;
                            preset_r  <= PRESET0;
                            ocupado_r <= 1'b0;
                        end
                    end else if (estado == ARM) begin
                        estado <= COUNT;
`ifdef SEQUENCIADOR_WATCHDOG_EN
                        timer  <= 6'd0;
`endif
                    end else begin
`ifdef SEQUENCIADOR_WATCHDOG_EN
                        if (timer == LIMITE) begin
                            estado <= ERRO;
                            erro_r <= 1'b1;
                        end else begin
                            timer <= timer + 6'd1;
                        end
`else
                        estado <= COUNT;
`endif
                    end
                end
                ERRO: begin
                    if (!bus.habilita) begin
                        estado    <= IDLE;
                        fase_r    <= 2'd0;
                        preset_r  <= PRESET0;
                        ocupado_r <= 1'b0;
                    end
                end
                default: begin
                    estado    <= IDLE;
                    fase_r    <= 2'd0;
                    preset_r  <= PRESET0;
                    ocupado_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.preset    = preset_r;
    assign bus.carga     = carga_r;
    assign bus.fase      = fase_r;
    assign bus.fim_ciclo = fim_r;
    assign bus.ocupado   = ocupado_r;
`ifdef SEQUENCIADOR_WATCHDOG_EN
    assign bus.erro      = erro_r;
`else
    assign bus.erro      = 1'b0;
`endif

endmodule

// File: tb/tb_sequenciador_contagem.sv
// tb_sequenciador_contagem
//   Directed bench for sequenciador_contagem with a behavioural model of the
//   4-bit presettable down counter. Expected load strobes and fim_ciclo
//   pulses are queued when stimulus is applied and checked when they appear.
module tb_sequenciador_contagem;

    typedef struct {
        int         cyc;
        logic [1:0] fase;
        logic [3:0] preset;
    } ev_t;

    logic clock = 1'b0;
    logic reset;
    logic stuck = 1'b0;
    logic [3:0] q_cnt = 4'd0;
    int cyc = 0;
    int n_cmp = 0;
    int n_fail = 0;

    ev_t ecarga[$];
    int  efim[$];
    ev_t mon_e;
    int  mon_f;

    sequenciador_contagem_if bus();

    sequenciador_contagem #(
        .PRESET0(4'd9),
        .PRESET1(4'd5),
        .PRESET2(4'd3),
        .PRESET3(4'd0),
        .MAX_CICLOS(32)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // Counter model: loads on carga, otherwise counts down and rests at zero.
    always @(posedge clock) begin
        if (bus.carga === 1'b1) q_cnt <= bus.preset;
        else if (q_cnt != 4'd0) q_cnt <= q_cnt - 4'd1;
    end
    assign bus.Q = stuck ? 4'd7 : q_cnt;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic push_carga(input int c, input logic [1:0] f, input logic [3:0] p);
        ecarga.push_back('{cyc: c, fase: f, preset: p});
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) @(negedge clock);
    endtask

    task automatic wait_drain(input int limit);
        for (int i = 0; i < limit; i++) begin
            if (ecarga.size() == 0 && efim.size() == 0) break;
            @(negedge clock);
        end
        check("carga_queue_drained", ecarga.size(), 0);
        check("fim_queue_drained", efim.size(), 0);
    endtask

    // Every observed strobe must match the oldest expected one; an
    // unexpected strobe is compared against cycle -1 and so fails.
    always @(negedge clock) begin
        if (reset === 1'b0 && bus.carga === 1'b1) begin
            if (ecarga.size() > 0) mon_e = ecarga.pop_front();
            else mon_e = '{cyc: -1, fase: 2'd0, preset: 4'd0};
            check("carga_cycle", cyc, mon_e.cyc);
            check("carga_fase", bus.fase, mon_e.fase);
            check("carga_preset", bus.preset, mon_e.preset);
        end
        if (reset === 1'b0 && bus.fim_ciclo === 1'b1) begin
            if (efim.size() > 0) mon_f = efim.pop_front();
            else mon_f = -1;
            check("fim_cycle", cyc, mon_f);
            check("fim_fase", bus.fase, 0);
        end
    end

    int base;

    initial begin
        reset = 1'b1;
        bus.habilita = 1'b0;
        repeat (3) @(negedge clock);
        check("rst_fase", bus.fase, 0);
        check("rst_preset", bus.preset, 9);
        check("rst_carga", bus.carga, 0);
        check("rst_fim", bus.fim_ciclo, 0);
        check("rst_ocupado", bus.ocupado, 0);
        check("rst_erro", bus.erro, 0);
        reset = 1'b0;
        repeat (2) @(negedge clock);
        check("idle_ocupado", bus.ocupado, 0);

        // Full default cycle (25 cycles), second cycle stopped during phase 1.
        base = cyc + 1;
        push_carga(base,      2'd0, 4'd9);
        push_carga(base + 11, 2'd1, 4'd5);
        push_carga(base + 18, 2'd2, 4'd3);
        push_carga(base + 23, 2'd3, 4'd0);
        push_carga(base + 25, 2'd0, 4'd9);
        push_carga(base + 36, 2'd1, 4'd5);
        efim.push_back(base + 25);
        bus.habilita = 1'b1;
        wait_until(base + 1);
        check("load_to_arm_carga", bus.carga, 0);
        check("run_ocupado", bus.ocupado, 1);
        wait_until(base + 24);
        check("p3_arm_fase", bus.fase, 3);
        check("p3_arm_carga", bus.carga, 0);
        wait_until(base + 40);
        bus.habilita = 1'b0;
        wait_until(base + 42);
        check("drop_still_busy", bus.ocupado, 1);
        check("drop_still_fase1", bus.fase, 1);
        wait_until(base + 43);
        check("stop_ocupado", bus.ocupado, 0);
        check("stop_fase", bus.fase, 0);
        check("stop_preset", bus.preset, 9);
        repeat (10) @(negedge clock);
        wait_drain(5);

        // Reset in the middle of phase 2's COUNT.
        base = cyc + 1;
        push_carga(base,      2'd0, 4'd9);
        push_carga(base + 11, 2'd1, 4'd5);
        push_carga(base + 18, 2'd2, 4'd3);
        bus.habilita = 1'b1;
        wait_until(base + 21);
        check("pre_rst_fase", bus.fase, 2);
        check("pre_rst_preset", bus.preset, 3);
        #2 reset = 1'b1;
        #1;
        check("async_rst_fase", bus.fase, 0);
        check("async_rst_preset", bus.preset, 9);
        check("async_rst_ocupado", bus.ocupado, 0);
        check("async_rst_carga", bus.carga, 0);
        bus.habilita = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        wait_drain(5);

        base = cyc + 1;
        push_carga(base,      2'd0, 4'd9);
        push_carga(base + 11, 2'd1, 4'd5);
        bus.habilita = 1'b1;
        wait_until(base + 12);
        bus.habilita = 1'b0;
        wait_until(base + 18);
        check("restart_stop_ocupado", bus.ocupado, 0);
        check("restart_stop_fase", bus.fase, 0);
        wait_drain(5);

        // Counter stuck at 7.
        stuck = 1'b1;
        base = cyc + 1;
        push_carga(base, 2'd0, 4'd9);
        bus.habilita = 1'b1;
`ifdef SEQUENCIADOR_WATCHDOG_EN
        wait_until(base + 33);
        check("wd_before_erro", bus.erro, 0);
        check("wd_before_ocupado", bus.ocupado, 1);
        wait_until(base + 34);
        check("wd_erro", bus.erro, 1);
        check("wd_carga", bus.carga, 0);
        check("wd_ocupado", bus.ocupado, 1);
        check("wd_fase", bus.fase, 0);
        wait_until(base + 50);
        check("wd_erro_held", bus.erro, 1);
        check("wd_ocupado_held", bus.ocupado, 1);
        bus.habilita = 1'b0;
        @(negedge clock);
        check("wd_idle_ocupado", bus.ocupado, 0);
        check("wd_idle_erro", bus.erro, 1);
        stuck = 1'b0;
        reset = 1'b1;
        @(negedge clock);
        check("wd_rst_erro", bus.erro, 0);
        reset = 1'b0;
        @(negedge clock);
`else
        wait_until(base + 34);
        check("nowd_erro", bus.erro, 0);
        check("nowd_ocupado", bus.ocupado, 1);
        wait_until(base + 60);
        check("nowd_erro_late", bus.erro, 0);
        check("nowd_carga_late", bus.carga, 0);
        check("nowd_fase_late", bus.fase, 0);
        bus.habilita = 1'b0;
        repeat (5) @(negedge clock);
        check("nowd_still_count", bus.ocupado, 1);
        stuck = 1'b0;
        @(negedge clock);
        check("nowd_release_idle", bus.ocupado, 0);
`endif
        wait_drain(5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
